// File: rtl/rob_param.sv
// Reorder buffer: circular entry store with in-order commit to the
// register file, the store port and the branch predictor.
//
// Commit FSM states
//   state      | meaning
//   S_IDLE     | examine head entry; commit reg-op/branch/jalr, or launch store
//   S_WAIT_MEM | store request issued; retire head when mem_done_i arrives
module rob_param #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = $clog2(DEPTH) + 1,
    parameter int DATA_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rdy_i,
    input  logic                   alloc_valid_i,
    input  logic [4:0]             alloc_dest_i,
    input  logic [DATA_W-1:0]      alloc_pc_i,
    input  logic                   alloc_pred_i,
    input  logic [1:0]             alloc_kind_i,
    input  logic [2:0]             alloc_size_i,
    output logic [TAG_W-1:0]       alloc_tag_o,
    output logic                   full_o,
    output logic [TAG_W-1:0]       count_o,
    input  logic [TAG_W-1:0]       wb0_tag_i,
    input  logic [DATA_W-1:0]      wb0_value_i,
    input  logic [DATA_W-1:0]      wb0_newpc_i,
    input  logic                   wb0_taken_i,
    input  logic [TAG_W-1:0]       wb1_tag_i,
    input  logic [DATA_W-1:0]      wb1_value_i,
    input  logic [DATA_W-1:0]      wb1_addr_i,
    input  logic [1:0][TAG_W-1:0]  q_tag_i,
    output logic [1:0][DATA_W-1:0] q_value_o,
    output logic [1:0]             q_ready_o,
    input  logic [DATA_W-1:0]      chk_addr_i,
    output logic                   chk_hit_o,
    output logic                   reg_we_o,
    output logic [4:0]             reg_index_o,
    output logic [TAG_W-1:0]       reg_tag_o,
    output logic [DATA_W-1:0]      reg_value_o,
    output logic                   mem_req_o,
    output logic [DATA_W-1:0]      mem_addr_o,
    output logic [DATA_W-1:0]      mem_data_o,
    output logic [2:0]             mem_size_o,
    input  logic                   mem_done_i,
    output logic                   bp_ce_o,
    output logic [DATA_W-1:0]      bp_pc_o,
    output logic                   bp_taken_o,
    output logic                   flush_o,
    output logic [DATA_W-1:0]      flush_pc_o
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] KIND_REG    = 2'd0;
    localparam logic [1:0] KIND_STORE  = 2'd1;
    localparam logic [1:0] KIND_BRANCH = 2'd2;
    localparam logic [1:0] KIND_JALR   = 2'd3;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]  head_q, tail_q;
    logic [TAG_W-1:0]  count_q;
    logic [DEPTH-1:0]  valid_q, ready_q, addr_valid_q;

    logic [4:0]        dest_q  [DEPTH];
    logic [1:0]        kind_q  [DEPTH];
    logic [2:0]        size_q  [DEPTH];
    logic [DATA_W-1:0] pc_q    [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DATA_W-1:0] newpc_q [DEPTH];
    logic [DATA_W-1:0] addr_q  [DEPTH];
    logic [DEPTH-1:0]  pred_q, taken_q;

    logic              reg_we_q, mem_req_q, bp_ce_q, flush_q, flush_pend_q;
    logic [4:0]        reg_index_q;
    logic [TAG_W-1:0]  reg_tag_q;
    logic [DATA_W-1:0] reg_value_q, mem_addr_q, mem_data_q, bp_pc_q, flush_pc_q;
    logic [2:0]        mem_size_q;
    logic              bp_taken_q;

    logic              reg_we_d, mem_req_d, bp_ce_d, mispred_d, do_retire;
    logic [DATA_W-1:0] redirect_pc_d;
    logic              head_ok;

    logic              do_alloc, do_wb0, do_wb1, flush_go;
    logic [IDX_W-1:0]  wb0_idx, wb1_idx;

    // Tag 0 means "no entry"; tag n lives in slot n-1.
    function automatic logic [IDX_W-1:0] tag_to_idx(input logic [TAG_W-1:0] tag);
        return IDX_W'(tag - TAG_W'(1));
    endfunction

    assign full_o      = (count_q == TAG_W'(DEPTH));
    assign count_o     = count_q;
    assign alloc_tag_o = TAG_W'(tail_q) + TAG_W'(1);

    // Full comes from the registered count, so a same-edge retire never frees a slot early.
    assign do_alloc = alloc_valid_i && !full_o && rdy_i && !flush_q;
    assign do_wb0   = rdy_i && !flush_q && (wb0_tag_i != '0);
    assign do_wb1   = rdy_i && !flush_q && (wb1_tag_i != '0);
    assign flush_go = rdy_i && flush_pend_q;
    assign wb0_idx  = tag_to_idx(wb0_tag_i);
    assign wb1_idx  = tag_to_idx(wb1_tag_i);

    assign reg_we_o    = reg_we_q;
    assign reg_index_o = reg_index_q;
    assign reg_tag_o   = reg_tag_q;
    assign reg_value_o = reg_value_q;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;
    assign mem_size_o  = mem_size_q;
    assign bp_ce_o     = bp_ce_q;
    assign bp_pc_o     = bp_pc_q;
    assign bp_taken_o  = bp_taken_q;
    assign flush_o     = flush_q;
    assign flush_pc_o  = flush_pc_q;

    // Operand lookup for the two issue-side tag ports.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            q_value_o[i] = value_q[tag_to_idx(q_tag_i[i])];
            q_ready_o[i] = (q_tag_i[i] != '0) && ready_q[tag_to_idx(q_tag_i[i])];
        end
    end

    // Collision check against every live store whose address is known.
    always_comb begin
        chk_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_valid_q[i] && (kind_q[i] == KIND_STORE) &&
                (addr_q[i] == chk_addr_i)) begin
                chk_hit_o = 1'b1;
            end
        end
    end

    // Commit FSM next-state and commit actions for the head entry.
    always_comb begin
        state_d       = state_q;
        reg_we_d      = 1'b0;
        mem_req_d     = 1'b0;
        bp_ce_d       = 1'b0;
        mispred_d     = 1'b0;
        do_retire     = 1'b0;
        redirect_pc_d = '0;
        // A pending redirect blocks commit so wrong-path entries never retire.
        head_ok = rdy_i && !flush_q && !flush_pend_q && (count_q != '0) && ready_q[head_q];
        case (state_q)
            S_IDLE: begin
                if (head_ok) begin
                    case (kind_q[head_q])
                        KIND_REG: begin
                            reg_we_d  = 1'b1;
                            do_retire = 1'b1;
                        end
                        KIND_STORE: begin
                            mem_req_d = 1'b1;
                            state_d   = S_WAIT_MEM;
                        end
                        KIND_BRANCH: begin
                            bp_ce_d   = 1'b1;
                            do_retire = 1'b1;
                            if (taken_q[head_q] != pred_q[head_q]) begin
                                mispred_d     = 1'b1;
                                redirect_pc_d = taken_q[head_q] ? newpc_q[head_q]
                                                                : pc_q[head_q] + DATA_W'(4);
                            end
                        end
                        default: begin
                            reg_we_d      = 1'b1;
                            do_retire     = 1'b1;
                            mispred_d     = 1'b1;
                            redirect_pc_d = newpc_q[head_q];
                        end
                    endcase
                end
            end
            default: begin
                if (rdy_i && mem_done_i) begin
                    do_retire = 1'b1;
                    state_d   = S_IDLE;
                end
            end
        endcase
    end

    // Commit FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else if (flush_go) begin
            state_q <= S_IDLE;
        end else if (rdy_i) begin
            state_q <= state_d;
        end
    end

    // Pointers, occupancy and per-entry status bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            ready_q      <= '0;
            addr_valid_q <= '0;
        end else if (flush_go) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            ready_q      <= '0;
            addr_valid_q <= '0;
        end else if (rdy_i) begin
            if (do_retire) begin
                valid_q[head_q]      <= 1'b0;
                addr_valid_q[head_q] <= 1'b0;
            end
            if (do_alloc) begin
                valid_q[tail_q]      <= 1'b1;
                ready_q[tail_q]      <= 1'b0;
                addr_valid_q[tail_q] <= 1'b0;
            end
            if (do_wb1) begin
                ready_q[wb1_idx] <= 1'b1;
                if (kind_q[wb1_idx] == KIND_STORE) begin
                    addr_valid_q[wb1_idx] <= 1'b1;
                end
            end
            if (do_wb0) begin
                ready_q[wb0_idx] <= 1'b1;
            end
            head_q  <= head_q + IDX_W'(do_retire);
            tail_q  <= tail_q + IDX_W'(do_alloc);
            count_q <= count_q + TAG_W'(do_alloc) - TAG_W'(do_retire);
        end
    end

    // Entry payload; wb0 is written last so it wins a same-tag collision.
    always_ff @(posedge clk_i) begin
        if (do_alloc) begin
            dest_q[tail_q] <= alloc_dest_i;
            kind_q[tail_q] <= alloc_kind_i;
            size_q[tail_q] <= alloc_size_i;
            pc_q[tail_q]   <= alloc_pc_i;
            pred_q[tail_q] <= alloc_pred_i;
        end
        if (do_wb1) begin
            value_q[wb1_idx] <= wb1_value_i;
            if (kind_q[wb1_idx] == KIND_STORE) begin
                addr_q[wb1_idx] <= wb1_addr_i;
            end
        end
        if (do_wb0) begin
            value_q[wb0_idx] <= wb0_value_i;
            newpc_q[wb0_idx] <= wb0_newpc_i;
            taken_q[wb0_idx] <= wb0_taken_i;
        end
    end

    // Registered one-cycle commit pulses with their payloads, and the redirect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_we_q     <= 1'b0;
            mem_req_q    <= 1'b0;
            bp_ce_q      <= 1'b0;
            flush_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            reg_index_q  <= '0;
            reg_tag_q    <= '0;
            reg_value_q  <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_size_q   <= '0;
            bp_pc_q      <= '0;
            bp_taken_q   <= 1'b0;
            flush_pc_q   <= '0;
        end else begin
            reg_we_q  <= 1'b0;
            mem_req_q <= 1'b0;
            bp_ce_q   <= 1'b0;
            flush_q   <= 1'b0;
            if (rdy_i) begin
                reg_we_q     <= reg_we_d;
                mem_req_q    <= mem_req_d;
                bp_ce_q      <= bp_ce_d;
                flush_q      <= flush_pend_q;
                flush_pend_q <= mispred_d;
                if (reg_we_d) begin
                    reg_index_q <= dest_q[head_q];
                    reg_tag_q   <= TAG_W'(head_q) + TAG_W'(1);
                    reg_value_q <= value_q[head_q];
                end
                if (mem_req_d) begin
                    mem_addr_q <= addr_q[head_q];
                    mem_data_q <= value_q[head_q];
                    mem_size_q <= size_q[head_q];
                end
                if (bp_ce_d) begin
                    bp_pc_q    <= pc_q[head_q];
                    bp_taken_q <= taken_q[head_q];
                end
                if (mispred_d) begin
                    flush_pc_q <= redirect_pc_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param (DEPTH=4): directed scenarios, then random
// reg-op/store traffic compared against an in-order queue model.
module tb_rob_param;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;

    logic                   clk, rst, rdy;
    logic                   alloc_valid;
    logic [4:0]             alloc_dest;
    logic [DATA_W-1:0]      alloc_pc;
    logic                   alloc_pred;
    logic [1:0]             alloc_kind;
    logic [2:0]             alloc_size;
    logic [TAG_W-1:0]       alloc_tag;
    logic                   full;
    logic [TAG_W-1:0]       count;
    logic [TAG_W-1:0]       wb0_tag;
    logic [DATA_W-1:0]      wb0_value, wb0_newpc;
    logic                   wb0_taken;
    logic [TAG_W-1:0]       wb1_tag;
    logic [DATA_W-1:0]      wb1_value, wb1_addr;
    logic [1:0][TAG_W-1:0]  q_tag;
    logic [1:0][DATA_W-1:0] q_value;
    logic [1:0]             q_ready;
    logic [DATA_W-1:0]      chk_addr;
    logic                   chk_hit;
    logic                   reg_we;
    logic [4:0]             reg_index;
    logic [TAG_W-1:0]       reg_tag;
    logic [DATA_W-1:0]      reg_value;
    logic                   mem_req;
    logic [DATA_W-1:0]      mem_addr, mem_data;
    logic [2:0]             mem_size;
    logic                   mem_done;
    logic                   bp_ce;
    logic [DATA_W-1:0]      bp_pc;
    logic                   bp_taken;
    logic                   flush;
    logic [DATA_W-1:0]      flush_pc;

    int errors = 0;
    int checks = 0;

    rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_i(rst), .rdy_i(rdy),
        .alloc_valid_i(alloc_valid), .alloc_dest_i(alloc_dest), .alloc_pc_i(alloc_pc),
        .alloc_pred_i(alloc_pred), .alloc_kind_i(alloc_kind), .alloc_size_i(alloc_size),
        .alloc_tag_o(alloc_tag), .full_o(full), .count_o(count),
        .wb0_tag_i(wb0_tag), .wb0_value_i(wb0_value), .wb0_newpc_i(wb0_newpc),
        .wb0_taken_i(wb0_taken),
        .wb1_tag_i(wb1_tag), .wb1_value_i(wb1_value), .wb1_addr_i(wb1_addr),
        .q_tag_i(q_tag), .q_value_o(q_value), .q_ready_o(q_ready),
        .chk_addr_i(chk_addr), .chk_hit_o(chk_hit),
        .reg_we_o(reg_we), .reg_index_o(reg_index), .reg_tag_o(reg_tag),
        .reg_value_o(reg_value),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
        .mem_size_o(mem_size), .mem_done_i(mem_done),
        .bp_ce_o(bp_ce), .bp_pc_o(bp_pc), .bp_taken_o(bp_taken),
        .flush_o(flush), .flush_pc_o(flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alloc_valid = 0; alloc_dest = 0; alloc_pc = 0; alloc_pred = 0;
        alloc_kind = 0; alloc_size = 0;
        wb0_tag = 0; wb0_value = 0; wb0_newpc = 0; wb0_taken = 0;
        wb1_tag = 0; wb1_value = 0; wb1_addr = 0;
        q_tag = '0; chk_addr = 0; mem_done = 0;
    endtask

    task automatic do_reset();
        rst = 1; rdy = 1;
        clear_inputs();
        tick(); tick();
        rst = 0;
    endtask

    task automatic alloc_op(input logic [1:0] k, input logic [4:0] d,
                            input logic [31:0] pc, input logic pr, input logic [2:0] sz);
        alloc_valid = 1; alloc_kind = k; alloc_dest = d;
        alloc_pc = pc; alloc_pred = pr; alloc_size = sz;
        tick();
        alloc_valid = 0;
    endtask

    task automatic wb0_op(input logic [TAG_W-1:0] t, input logic [31:0] v,
                          input logic [31:0] npc, input logic tk);
        wb0_tag = t; wb0_value = v; wb0_newpc = npc; wb0_taken = tk;
        tick();
        wb0_tag = 0;
    endtask

    // Reference model: live entries in program order.
    typedef struct {
        int          tag;
        int          kind;
        logic [4:0]  dest;
        logic [31:0] value;
        bit          ready;
        bit          av;
        logic [31:0] addr;
        logic [2:0]  size;
    } ent_t;

    ent_t        mq[$];
    int          next_tag;
    bit          m_wait;
    bit          exp_we, exp_mreq, exp_hit, retire, full_pre, found;
    logic [4:0]  exp_idx;
    int          exp_tag;
    logic [31:0] exp_val, exp_addr, exp_data;
    logic [2:0]  exp_size;
    int          cand[$];
    int          k, mode;
    ent_t        ne;
    logic [31:0] addr_set [3];

    initial begin
        addr_set[0] = 32'h100; addr_set[1] = 32'h104; addr_set[2] = 32'h108;

        // Reset state
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_alloc_tag", alloc_tag, 1);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_bp_ce", bp_ce, 0);
        chk("rst_flush", flush, 0);
        chk("rst_chk_hit", chk_hit, 0);

        // Fill to DEPTH, refused 5th alloc, retire-while-full, tail wrap
        for (int i = 1; i <= 4; i++) begin
            chk("fill_tag", alloc_tag, i);
            alloc_op(2'd0, 5'(4 + i), 32'h0, 1'b0, 3'd4);
        end
        chk("fill_count", count, 4);
        chk("fill_full", full, 1);
        chk("fill_wrap_tag", alloc_tag, 1);
        alloc_op(2'd0, 5'd20, 32'h0, 1'b0, 3'd4);
        chk("over_count", count, 4);
        chk("over_tag", alloc_tag, 1);
        wb0_op(3'd1, 32'h2A, 32'h0, 1'b0);
        chk("pre_commit_we", reg_we, 0);
        alloc_valid = 1; alloc_dest = 5'd9; alloc_kind = 2'd0;
        tick();
        chk("commit_we", reg_we, 1);
        chk("commit_index", reg_index, 5);
        chk("commit_tag", reg_tag, 1);
        chk("commit_value", reg_value, 32'h2A);
        chk("full_refuse_count", count, 3);
        tick();
        alloc_valid = 0;
        chk("wrap_alloc_count", count, 4);
        chk("wrap_alloc_tag", alloc_tag, 2);
        chk("we_pulse_low", reg_we, 0);
        q_tag[0] = 3'd1; #1;
        chk("realloc_not_ready", q_ready[0], 0);
        q_tag[0] = 0;

        // Store: address collision, mem handshake, lost mem_done with rdy low
        do_reset();
        alloc_op(2'd1, 5'd0, 32'h0, 1'b0, 3'd4);
        wb1_tag = 3'd1; wb1_value = 32'd7; wb1_addr = 32'h100; chk_addr = 32'h100;
        tick();
        wb1_tag = 0;
        chk("st_hit", chk_hit, 1);
        chk("st_mreq_early", mem_req, 0);
        chk_addr = 32'h104; #1;
        chk("st_nohit", chk_hit, 0);
        chk_addr = 32'h100;
        tick();
        chk("st_mreq", mem_req, 1);
        chk("st_maddr", mem_addr, 32'h100);
        chk("st_mdata", mem_data, 7);
        chk("st_msize", mem_size, 4);
        tick();
        chk("st_mreq_pulse", mem_req, 0);
        rdy = 0; mem_done = 1;
        tick();
        chk("st_lost_done", count, 1);
        rdy = 1; mem_done = 0;
        tick();
        chk("st_still_wait", count, 1);
        chk("st_hit_wait", chk_hit, 1);
        mem_done = 1;
        tick();
        mem_done = 0;
        chk("st_retire", count, 0);
        chk("st_hit_gone", chk_hit, 0);

        // Mispredicted branch with a younger entry, flush ignores alloc
        do_reset();
        alloc_op(2'd2, 5'd0, 32'h40, 1'b1, 3'd0);
        alloc_op(2'd0, 5'd3, 32'h44, 1'b0, 3'd0);
        wb0_op(3'd1, 32'h0, 32'h80, 1'b0);
        tick();
        chk("br_bp_ce", bp_ce, 1);
        chk("br_bp_pc", bp_pc, 32'h40);
        chk("br_bp_taken", bp_taken, 0);
        chk("br_no_flush_yet", flush, 0);
        chk("br_count", count, 1);
        wb0_tag = 3'd2; wb0_value = 32'd9;
        tick();
        wb0_tag = 0;
        chk("br_flush", flush, 1);
        chk("br_flush_pc", flush_pc, 32'h44);
        chk("br_flush_count", count, 0);
        chk("br_no_wrong_path", reg_we, 0);
        alloc_valid = 1;
        tick();
        alloc_valid = 0;
        chk("flush_pulse", flush, 0);
        chk("flush_alloc_ignored", count, 0);
        chk("flush_tag", alloc_tag, 1);

        // Correct prediction: no flush; taken-not-predicted: redirect to target
        alloc_op(2'd2, 5'd0, 32'h50, 1'b1, 3'd0);
        wb0_op(3'd1, 32'h0, 32'h90, 1'b1);
        tick();
        chk("br2_bp_ce", bp_ce, 1);
        chk("br2_bp_taken", bp_taken, 1);
        tick();
        chk("br2_no_flush", flush, 0);
        alloc_op(2'd2, 5'd0, 32'h60, 1'b0, 3'd0);
        wb0_op(3'd2, 32'h0, 32'hA0, 1'b1);
        tick();
        chk("br3_bp_pc", bp_pc, 32'h60);
        tick();
        chk("br3_flush", flush, 1);
        chk("br3_flush_pc", flush_pc, 32'hA0);
        tick();

        // JALR: link write then redirect
        alloc_op(2'd3, 5'd1, 32'h200, 1'b0, 3'd0);
        wb0_op(3'd1, 32'h204, 32'h300, 1'b0);
        tick();
        chk("jalr_we", reg_we, 1);
        chk("jalr_index", reg_index, 1);
        chk("jalr_value", reg_value, 32'h204);
        chk("jalr_bp_ce", bp_ce, 0);
        tick();
        chk("jalr_flush", flush, 1);
        chk("jalr_flush_pc", flush_pc, 32'h300);
        tick();

        // Same-cycle wb0/wb1 to one tag
        do_reset();
        alloc_op(2'd0, 5'd1, 32'h0, 1'b0, 3'd0);
        alloc_op(2'd0, 5'd2, 32'h0, 1'b0, 3'd0);
        wb0_tag = 3'd2; wb0_value = 32'd1; wb1_tag = 3'd2; wb1_value = 32'd2;
        tick();
        wb0_tag = 0; wb1_tag = 0;
        q_tag[0] = 3'd2; q_tag[1] = 3'd1; #1;
        chk("dual_wb_value", q_value[0], 1);
        chk("dual_wb_ready", q_ready[0], 1);
        chk("q_not_ready", q_ready[1], 0);
        q_tag[1] = 3'd0; #1;
        chk("q_tag0", q_ready[1], 0);
        q_tag = '0;

        // Reset while waiting on memory
        do_reset();
        alloc_op(2'd1, 5'd0, 32'h0, 1'b0, 3'd2);
        wb1_tag = 3'd1; wb1_value = 32'd3; wb1_addr = 32'h10; chk_addr = 32'h10;
        tick();
        wb1_tag = 0;
        tick();
        chk("rw_mreq", mem_req, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("rw_count", count, 0);
        chk("rw_mreq_low", mem_req, 0);
        chk("rw_hit_low", chk_hit, 0);
        mem_done = 1;
        tick();
        mem_done = 0;
        chk("rw_done_ignored", count, 0);
        alloc_op(2'd0, 5'd4, 32'h0, 1'b0, 3'd0);
        wb0_op(3'd1, 32'h55, 32'h0, 1'b0);
        tick();
        chk("rw_idle_commit", reg_we, 1);
        chk("rw_idle_value", reg_value, 32'h55);

        // Random reg-op/store traffic against the queue model
        do_reset();
        mq.delete();
        next_tag = 1;
        m_wait = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rdy = ($urandom_range(0, 7) != 0);
            alloc_valid = $urandom_range(0, 1);
            alloc_kind = 2'($urandom_range(0, 1));
            alloc_dest = 5'($urandom_range(0, 31));
            alloc_pc = $urandom;
            alloc_pred = 0;
            k = $urandom_range(0, 2);
            alloc_size = (k == 0) ? 3'd1 : (k == 1) ? 3'd2 : 3'd4;
            wb0_tag = 0; wb1_tag = 0;
            wb0_value = $urandom; wb1_value = $urandom; wb0_newpc = $urandom; wb0_taken = 0;
            wb1_addr = addr_set[$urandom_range(0, 2)];
            cand.delete();
            for (int i = 0; i < mq.size(); i++) if (!mq[i].ready) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                k = cand[$urandom_range(0, cand.size() - 1)];
                if (mq[k].kind == 1) begin
                    wb1_tag = TAG_W'(mq[k].tag);
                end else begin
                    mode = $urandom_range(0, 2);
                    if (mode != 1) wb0_tag = TAG_W'(mq[k].tag);
                    if (mode != 0) wb1_tag = TAG_W'(mq[k].tag);
                end
            end
            mem_done = $urandom_range(0, 1);
            chk_addr = addr_set[$urandom_range(0, 2)];
            q_tag[0] = TAG_W'($urandom_range(0, 4));
            q_tag[1] = TAG_W'($urandom_range(0, 4));
            #1;

            exp_hit = 0;
            foreach (mq[i]) if (mq[i].kind == 1 && mq[i].av && mq[i].addr == chk_addr) exp_hit = 1;
            chk("rnd_chk_hit", chk_hit, exp_hit);
            for (int p = 0; p < 2; p++) begin
                if (q_tag[p] == 0) begin
                    chk("rnd_q_none", q_ready[p], 0);
                end else begin
                    found = 0;
                    foreach (mq[i]) begin
                        if (mq[i].tag == int'(q_tag[p]) && !found) begin
                            found = 1;
                            chk("rnd_q_ready", q_ready[p], mq[i].ready);
                            if (mq[i].ready) chk("rnd_q_value", q_value[p], mq[i].value);
                        end
                    end
                end
            end

            exp_we = 0; exp_mreq = 0;
            if (rdy) begin
                retire = 0;
                full_pre = (mq.size() == DEPTH);
                if (!m_wait && mq.size() > 0 && mq[0].ready) begin
                    if (mq[0].kind == 0) begin
                        exp_we = 1; exp_idx = mq[0].dest; exp_tag = mq[0].tag;
                        exp_val = mq[0].value; retire = 1;
                    end else begin
                        exp_mreq = 1; exp_addr = mq[0].addr; exp_data = mq[0].value;
                        exp_size = mq[0].size; m_wait = 1;
                    end
                end else if (m_wait && mem_done) begin
                    retire = 1; m_wait = 0;
                end
                foreach (mq[i]) begin
                    if (wb1_tag != 0 && mq[i].tag == int'(wb1_tag)) begin
                        mq[i].value = wb1_value; mq[i].ready = 1;
                        if (mq[i].kind == 1) begin mq[i].av = 1; mq[i].addr = wb1_addr; end
                    end
                    if (wb0_tag != 0 && mq[i].tag == int'(wb0_tag)) begin
                        mq[i].value = wb0_value; mq[i].ready = 1;
                    end
                end
                if (alloc_valid && !full_pre) begin
                    ne.tag = next_tag; ne.kind = int'(alloc_kind); ne.dest = alloc_dest;
                    ne.value = 0; ne.ready = 0; ne.av = 0; ne.addr = 0; ne.size = alloc_size;
                    mq.push_back(ne);
                    next_tag = next_tag % DEPTH + 1;
                end
                if (retire) void'(mq.pop_front());
            end

            tick();
            chk("rnd_count", count, mq.size());
            chk("rnd_full", full, (mq.size() == DEPTH));
            chk("rnd_alloc_tag", alloc_tag, next_tag);
            chk("rnd_reg_we", reg_we, exp_we);
            if (exp_we) begin
                chk("rnd_reg_index", reg_index, exp_idx);
                chk("rnd_reg_tag", reg_tag, exp_tag);
                chk("rnd_reg_value", reg_value, exp_val);
            end
            chk("rnd_mem_req", mem_req, exp_mreq);
            if (exp_mreq) begin
                chk("rnd_mem_addr", mem_addr, exp_addr);
                chk("rnd_mem_data", mem_data, exp_data);
                chk("rnd_mem_size", mem_size, exp_size);
            end
            chk("rnd_flush", flush, 0);
            chk("rnd_bp_ce", bp_ce, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rob_param.md
ROB_PARAM -- requirements
Module: rob_param

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (power of two, 4..64).
REQ-002 SHALL have parameter TAG_W, default $clog2(DEPTH)+1, tag width; tag = entry index + 1; tag 0 = none.
REQ-003 SHALL have parameter DATA_W, default 32, value/address/PC width.
REQ-004 SHALL have ports: clk in 1, clock; rst in 1, reset, synchronous active-high; rdy in 1, global enable.
REQ-005 SHALL have: alloc_valid in 1; alloc_dest in 5 (register index); alloc_pc in DATA_W; alloc_pred in 1 (predicted taken).
REQ-006 SHALL have: alloc_kind in 2 (0 reg-op, 1 store, 2 branch, 3 jalr); alloc_size in 3 (store bytes 1/2/4).
REQ-007 SHALL have: alloc_tag out TAG_W, tag the next allocation receives; full out 1; count out TAG_W, live entries.
REQ-008 SHALL have: wb0_tag in TAG_W; wb0_value in DATA_W; wb0_newpc in DATA_W; wb0_taken in 1 (ALU writeback).
REQ-009 SHALL have: wb1_tag in TAG_W; wb1_value in DATA_W; wb1_addr in DATA_W (LSB writeback, store address).
REQ-010 SHALL have: q_tag[2] in TAG_W each; q_value[2] out DATA_W; q_ready[2] out 1 (operand lookup).
REQ-011 SHALL have: chk_addr in DATA_W; chk_hit out 1 (pending-store collision).
REQ-012 SHALL have: reg_we out 1; reg_index out 5; reg_tag out TAG_W; reg_value out DATA_W (commit to register file).
REQ-013 SHALL have: mem_req out 1; mem_addr out DATA_W; mem_data out DATA_W; mem_size out 3; mem_done in 1.
REQ-014 SHALL have: bp_ce out 1; bp_pc out DATA_W; bp_taken out 1; flush out 1; flush_pc out DATA_W.

Function
REQ-015 SHALL be a circular buffer: head, tail pointers, index 0..DEPTH-1, wrap DEPTH-1 -> 0; full = (count == DEPTH).
REQ-016 SHALL accept allocation when alloc_valid && !full && rdy && !flush; entry written, ready=0, tail++, count++.
REQ-017 SHALL combinationally drive alloc_tag = tail+1 and q_value/q_ready from entry q_tag-1; q_tag 0 -> ready 0.
REQ-018 SHALL on wb0_tag != 0 store value, newpc, taken, ready=1; on wb1_tag != 0 store value, ready=1, and for stores addr=wb1_addr, addr_valid=1.
REQ-019 SHALL, when wb0_tag == wb1_tag != 0 same cycle, take value from wb0.
REQ-020 SHALL drive chk_hit = 1 iff any live store entry has addr_valid and addr == chk_addr (full-width compare).
REQ-021 SHALL run a commit FSM: IDLE, WAIT_MEM; commit only head entry, only when count != 0 and head ready.
REQ-022 SHALL in IDLE, reg-op head: one-cycle reg_we pulse with dest/tag/value, retire (head++, count--) same edge.
REQ-023 SHALL in IDLE, store head: one-cycle mem_req pulse with addr/value/size, go WAIT_MEM; retire on mem_done, return IDLE.
REQ-024 SHALL for branch head: one-cycle bp_ce (bp_pc=pc, bp_taken=taken), retire; if taken != pred, flush next cycle with flush_pc = taken ? newpc : pc+4.
REQ-025 SHALL for jalr head: reg_we pulse with link value, retire, flush with flush_pc = newpc.
REQ-026 SHALL make flush a one-cycle registered pulse; during that cycle ignore alloc/wb, clear all entries, head=tail=count=0, FSM=IDLE.
REQ-027 SHALL count alloc and retire on the same edge as net 0; full is from registered count, so alloc at full is refused even if head retires.
REQ-028 SHALL, with rdy low, hold all state; mem_done arriving with rdy low is lost (memory side holds it until rdy).
REQ-029 SHALL hold reg_we, mem_req, bp_ce low except in their commit cycle.

Reset
REQ-030 SHALL on rst: head=tail=count=0, all ready/valid/addr_valid=0, FSM=IDLE, reg_we=mem_req=bp_ce=flush=0, including mid-WAIT_MEM.
REQ-031 SHALL give rst priority over rdy and flush.

Verification
REQ-032 DEPTH=4: 4 allocs -> tags 1,2,3,4, full=1, count=4; 5th alloc ignored; wb tag1, commit -> alloc_tag=1 (wrap).
REQ-033 Alloc reg-op dest=5; wb0 tag1 value=0x2A -> next cycle reg_we=1, reg_index=5, reg_value=0x2A, count=0.
REQ-034 Store size 4, wb1 addr=0x100 value=7 -> chk_addr=0x100 hit=1; mem_req with addr 0x100; mem_done 3 cycles later -> retire, hit=0.
REQ-035 Branch pc=0x40 pred=1, wb0 taken=0 -> bp_ce, next cycle flush=1 flush_pc=0x44, count=0; pred=taken -> no flush.
REQ-036 Same-cycle wb0/wb1 to tag2 (values 1, 2) -> q_value=1; rst during WAIT_MEM -> FSM IDLE, count=0, mem_req=0.
